// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a registered carry produces a WIDTH-bit
// sum LSB first, then presents {cout, sum} alongside a single-cycle done pulse.

module fulladder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic sum,
    output logic carry
);
    assign sum   = A ^ B ^ C;
    assign carry = (A & B) | (C & (A ^ B));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_adder: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_sum;
    logic               fa_carry;
    logic               accept;
    logic               last_bit;

    fulladder u_fa (
        .A     (a_sr_q[0]),
        .B     (b_sr_q[0]),
        .C     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // A new operation can be taken in IDLE or in the DONE cycle (back-to-back).
    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy = (state_q == S_SHIFT);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        if (accept) begin
            cnt_d   = '0;
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
        end else if (state_q == S_SHIFT) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            // New bit enters at the MSB; the oldest LSB falls off the bottom.
            res_sr_d = WIDTH'({fa_sum, res_sr_q} >> 1);
            carry_d  = fa_carry;
            cnt_d    = cnt_q + 1'b1;
            if (last_bit) begin
                sum_d  = res_sr_d;
                cout_d = fa_carry;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): reset, sums, carry chain, busy protection,
// mid-operation reset and back-to-back operation, with hand-computed results.

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to its done pulse.
    // glitch > 0 re-asserts start (with other operands) in that SHIFT cycle.
    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] exp_sum, input logic exp_cout,
                          input logic [7:0] prev_sum, input int glitch);
        int edges;
        int busy_cycles;
        int overlap;
        int sum_moved;
        int extra_done;
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = ~bv; cin = ~cv;
        edges = 1; busy_cycles = 0; overlap = 0; sum_moved = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            if (busy && done) overlap++;
            if (sum !== prev_sum) sum_moved++;
            if (edges == glitch) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check({name, " latency"}, edges, WIDTH + 1);
        check({name, " busy_cycles"}, busy_cycles, WIDTH);
        check({name, " partial_visible"}, sum_moved, 0);
        check({name, " busy_done_overlap"}, overlap, 0);
        check({name, " done"}, done, 1);
        check({name, " busy_at_done"}, busy, 0);
        check({name, " sum"}, sum, exp_sum);
        check({name, " cout"}, cout, exp_cout);
        $display("op %s: a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d (latency %0d)",
                 name, av, bv, cv, sum, cout, edges);
        @(negedge clk);
        check({name, " done_pulse_width"}, done, 0);
        check({name, " sum_hold"}, sum, exp_sum);
        if (glitch > 0) begin
            extra_done = 0;
            for (int i = 0; i < 15; i++) begin
                if (done || busy) extra_done++;
                @(negedge clk);
            end
            check({name, " second_request_dropped"}, extra_done, 0);
        end
    endtask

    initial begin
        int cyc;
        int done_seen;
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;

        // Reset held for two edges with start asserted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst busy", busy, 0);
            check("rst done", done, 0);
            check("rst sum", sum, 8'h00);
            check("rst cout", cout, 0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst no_start", busy, 0);
        $display("reset: busy=%0d done=%0d sum=0x%02h cout=%0d", busy, done, sum, cout);

        run_op("basic",   8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 8'h00, 0);
        run_op("carry1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h8D, 0);
        run_op("carry2",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 0);
        run_op("busyprot", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'hFF, 3);

        // Reset at the 4th SHIFT edge (E4).
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);                       // after E0
        start = 1'b0;
        @(negedge clk);                       // after E1
        @(negedge clk);                       // after E2
        @(negedge clk);                       // after E3
        rst = 1'b1;
        @(negedge clk);                       // after E4
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst sum", sum, 8'h00);
        check("midrst cout", cout, 0);
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) done_seen++;
            @(negedge clk);
        end
        check("midrst no_done", done_seen, 0);
        $display("op midrst: a=0x7F b=0x01 aborted -> sum=0x%02h cout=%0d", sum, cout);

        // Back-to-back with start held high throughout.
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(negedge clk);                       // after E0 of first op
        a = 8'h80; b = 8'h80; cin = 1'b1;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b first latency", cyc, WIDTH + 1);
        check("b2b first sum", sum, 8'h03);
        check("b2b first cout", cout, 0);
        $display("op b2b1: a=0x01 b=0x02 cin=0 -> sum=0x%02h cout=%0d", sum, cout);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("b2b busy_after_done", busy, 1);
                check("b2b sum_hold", sum, 8'h03);
                start = 1'b0;
            end
        end while (!done && cyc < 40);
        check("b2b second spacing", cyc, WIDTH + 1);
        check("b2b second sum", sum, 8'h01);
        check("b2b second cout", cout, 1);
        $display("op b2b2: a=0x80 b=0x80 cin=1 -> sum=0x%02h cout=%0d", sum, cout);
        @(negedge clk);
        check("b2b idle_after", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
